// File: rtl/seq_pkg.sv
// Shared sequencer types: pitch/index widths, rest pitch and player states.
// Imported by the beat_player slice and the sequencer data model.
package seq_pkg;

    localparam int NUM_BEATS_DEFAULT = 16;

    typedef logic [3:0] pitch_t;
    typedef logic [3:0] beat_idx_t;

    localparam pitch_t PITCH_REST = 4'd0;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } player_state_t;

endpackage

// File: rtl/beat_player_if.sv
// Pattern/transport/output bundle between UI, beat_player and tone generator.
// BEAT_PLAYER_LOOP_LEN_EN adds the loop_len field.
interface beat_player_if #(
    parameter int NUM_BEATS = 16,
    parameter int PERIOD_W  = 24
);
    import seq_pkg::*;

    logic [NUM_BEATS*4-1:0] beats;
    logic [PERIOD_W-1:0]    step_period;
    logic [PERIOD_W-1:0]    gate_len;
    logic                   start;
    logic                   pause;
    logic                   stop;
`ifdef BEAT_PLAYER_LOOP_LEN_EN
    logic [3:0]             loop_len;
`endif
    beat_idx_t              beat_idx;
    pitch_t                 pitch;
    logic                   gate;
    logic                   step_pulse;
    logic                   running;

`ifdef BEAT_PLAYER_LOOP_LEN_EN
    modport master (
        output beats, step_period, gate_len, start, pause, stop, loop_len,
        input  beat_idx, pitch, gate, step_pulse, running
    );
    modport slave (
        input  beats, step_period, gate_len, start, pause, stop, loop_len,
        output beat_idx, pitch, gate, step_pulse, running
    );
`else
    modport master (
        output beats, step_period, gate_len, start, pause, stop,
        input  beat_idx, pitch, gate, step_pulse, running
    );
    modport slave (
        input  beats, step_period, gate_len, start, pause, stop,
        output beat_idx, pitch, gate, step_pulse, running
    );
`endif

endinterface

// File: rtl/beat_player_step_timer.sv
// Per-step cycle counter: latches the effective period at each step start,
// counts up while enabled, flags the last cycle and pulses on the first.
module step_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] step_period_i,
    output logic [PERIOD_W-1:0] cnt_o,
    output logic [PERIOD_W-1:0] peff_o,
    output logic                last_o,
    output logic                first_o
);
    localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(2);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                first_q, first_d;

    // Periods below two would leave no room for a gate-low cycle.
    assign peff_o = (step_period_i < MIN_P) ? MIN_P : step_period_i;
    assign last_o = en_i && (cnt_q == period_q - ONE);

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        first_d  = 1'b0;
        if (clr_i) begin
            period_d = MIN_P;
            cnt_d    = '0;
        end else if (load_i || last_o) begin
            period_d = peff_o;
            cnt_d    = '0;
            first_d  = 1'b1;
        end else if (en_i) begin
            cnt_d    = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= MIN_P;
            cnt_q    <= '0;
            first_q  <= 1'b0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign first_o = first_q;

endmodule

// File: rtl/beat_player.sv
// Pattern playback: transport FSM, beat index, pitch capture and gate.
// Optional BEAT_PLAYER_LOOP_LEN_EN shortens the loop via bus.loop_len.
module beat_player
    import seq_pkg::*;
#(
    parameter int NUM_BEATS = NUM_BEATS_DEFAULT,
    parameter int PERIOD_W  = 24
) (
    input logic          clk,
    input logic          rst_n,
    beat_player_if.slave bus
);
    localparam beat_idx_t           LAST_IDX = beat_idx_t'(NUM_BEATS - 1);
    localparam logic [PERIOD_W-1:0] ONE      = PERIOD_W'(1);

    player_state_t       state_q, state_d;
    beat_idx_t           idx_q, idx_d, lim;
    pitch_t              pitch_q, pitch_d, pitch_sel;
    logic                gate_q, gate_d;
    logic [PERIOD_W-1:0] geff_q, geff_d;
    logic [PERIOD_W-1:0] cnt, peff, cnt_nx;
    logic                begin_s, en_s, last_s, first_s, step_go;

    step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (bus.stop),
        .load_i       (begin_s),
        .en_i         (en_s),
        .step_period_i(bus.step_period),
        .cnt_o        (cnt),
        .peff_o       (peff),
        .last_o       (last_s),
        .first_o      (first_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= STOPPED;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.stop)
            state_d = STOPPED;
        else if (bus.start && state_q != RUNNING)
            state_d = RUNNING;
        else if (bus.pause && !bus.start && state_q == RUNNING)
            state_d = PAUSED;
    end

    always_comb begin
        begin_s = (state_q == STOPPED) && (state_d == RUNNING);
        en_s    = (state_q == RUNNING) && (state_d == RUNNING);
    end

`ifdef BEAT_PLAYER_LOOP_LEN_EN
    assign lim = (bus.loop_len > LAST_IDX) ? LAST_IDX : bus.loop_len;
`else
    assign lim = LAST_IDX;
`endif

    assign step_go = begin_s || last_s;

    always_comb begin
        idx_d = idx_q;
        if (bus.stop || begin_s)
            idx_d = '0;
        else if (last_s)
            idx_d = (idx_q >= lim) ? '0 : idx_q + 4'd1;
    end

    always_comb begin
        pitch_sel = PITCH_REST;
        for (int i = 0; i < NUM_BEATS; i++)
            if (idx_d == beat_idx_t'(i)) pitch_sel = bus.beats[i*4 +: 4];
    end

    // Gate is evaluated from next-cycle values so the output stays registered.
    always_comb begin
        pitch_d = bus.stop ? PITCH_REST : (step_go ? pitch_sel : pitch_q);
        geff_d  = geff_q;
        if (step_go)
            geff_d = (bus.gate_len < peff - ONE) ? bus.gate_len : peff - ONE;
        cnt_nx = step_go ? '0 : (en_s ? cnt + ONE : cnt);
        gate_d = (state_d == RUNNING) && (pitch_d != PITCH_REST)
                 && (cnt_nx < geff_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            pitch_q <= PITCH_REST;
            gate_q  <= 1'b0;
            geff_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            pitch_q <= pitch_d;
            gate_q  <= gate_d;
            geff_q  <= geff_d;
        end
    end

    assign bus.beat_idx   = idx_q;
    assign bus.pitch      = pitch_q;
    assign bus.gate       = gate_q;
    assign bus.step_pulse = first_s;
    assign bus.running    = (state_q == RUNNING);

endmodule

// File: tb/tb_beat_player.sv
// Self-checking bench for beat_player: per-cycle model compare plus
// directed literal checks; loop-length test under BEAT_PLAYER_LOOP_LEN_EN.
module tb_beat_player;
    localparam int NB = 16;
    localparam int PW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    beat_player_if #(.NUM_BEATS(NB), .PERIOD_W(PW)) bus ();

    beat_player #(.NUM_BEATS(NB), .PERIOD_W(PW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference model: transport state, step position and step contents.
    int m_st, m_idx, m_cnt, m_per, m_geff, m_pitch;
    bit m_pulse;

    function automatic int nxt_idx(int i);
        int lim;
        lim = NB - 1;
`ifdef BEAT_PLAYER_LOOP_LEN_EN
        if (int'(bus.loop_len) < lim) lim = int'(bus.loop_len);
`endif
        return (i >= lim) ? 0 : i + 1;
    endfunction

    task automatic new_step(int i);
        int sp, gl;
        sp = int'(bus.step_period);
        gl = int'(bus.gate_len);
        m_idx   = i;
        m_cnt   = 0;
        m_per   = (sp < 2) ? 2 : sp;
        m_geff  = (gl < m_per - 1) ? gl : m_per - 1;
        m_pitch = int'((bus.beats >> (4 * i)) & 64'hF);
        m_pulse = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_idx = 0; m_cnt = 0; m_per = 2;
            m_geff = 0; m_pitch = 0; m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (bus.stop) begin
                m_st = 0; m_idx = 0; m_cnt = 0; m_pitch = 0;
            end else if (bus.start && m_st != 1) begin
                if (m_st == 0) new_step(0);
                m_st = 1;
            end else if (bus.pause && m_st == 1) begin
                m_st = 2;
            end else if (m_st == 1) begin
                if (m_cnt == m_per - 1) new_step(nxt_idx(m_idx));
                else m_cnt++;
            end
        end
    end

    function automatic int pack(int idx, int p, bit g, bit sp, bit r);
        return (idx << 8) | (p << 4) | (int'(g) << 2) | (int'(sp) << 1) | int'(r);
    endfunction

    always @(posedge clk) begin
        int exp_v, got_v;
        bit m_gate;
        #2;
        m_gate = (m_st == 1) && (m_pitch != 0) && (m_cnt < m_geff);
        exp_v = pack(m_idx, m_pitch, m_gate, m_pulse, m_st == 1);
        got_v = pack(int'(bus.beat_idx), int'(bus.pitch), bus.gate,
                     bus.step_pulse, bus.running);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL model t=%0t: got idx/pitch/flags %h expected %h",
                     $time, got_v, exp_v);
        end
    end

    task automatic chk(string nm, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin tick(1); n++; end while (!bus.step_pulse && n < 60);
        if (!bus.step_pulse) chk("pulse_timeout", 0, 1);
    endtask

    initial begin
        int n;
        logic [NB*4-1:0] pat;
        bus.beats = '0; bus.step_period = '0; bus.gate_len = '0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
`ifdef BEAT_PLAYER_LOOP_LEN_EN
        bus.loop_len = 4'd15;
`endif
        tick(2);
        chk("reset_idx", int'(bus.beat_idx), 0);
        chk("reset_run", int'(bus.running), 0);
        rst_n = 1'b1;
        tick(1);

        // all pitch 5, period 4, gate 2
        bus.beats = {NB{4'h5}}; bus.step_period = 4; bus.gate_len = 2;
        pulse_start();
        chk("t1_pulse0", int'(bus.step_pulse), 1);
        chk("t1_pitch0", int'(bus.pitch), 5);
        chk("t1_gate_c0", int'(bus.gate), 1);
        tick(1); chk("t1_gate_c1", int'(bus.gate), 1);
        tick(1); chk("t1_gate_c2", int'(bus.gate), 0);
        tick(1); chk("t1_gate_c3", int'(bus.gate), 0);
        tick(1); chk("t1_idx1", int'(bus.beat_idx), 1);
        chk("t1_pulse1", int'(bus.step_pulse), 1);
        tick(60);
        chk("t1_wrap_idx", int'(bus.beat_idx), 0);
        chk("t1_wrap_pulse", int'(bus.step_pulse), 1);
        pulse_stop();

        // beat 3 is a rest
        pat = {NB{4'h7}};
        pat[12 +: 4] = 4'h0;
        bus.beats = pat; bus.gate_len = 3;
        pulse_start();
        n = 0;
        while (bus.beat_idx != 4'd3 && n < 40) begin tick(1); n++; end
        chk("t2_reach3", int'(bus.beat_idx), 3);
        chk("t2_pitch3", int'(bus.pitch), 0);
        for (int i = 0; i < 4; i++) chk("t2_gate3", int'(bus.gate), 0);
        tick(4);
        chk("t2_pitch4", int'(bus.pitch), 7);

        pulse_stop();
        chk("stop_run", int'(bus.running), 0);
        chk("stop_idx", int'(bus.beat_idx), 0);
        chk("stop_pitch", int'(bus.pitch), 0);

        // period clamps to 2, gate to 1
        bus.beats = {NB{4'h5}}; bus.step_period = 1; bus.gate_len = 10;
        pulse_start();
        chk("t3_gate_a", int'(bus.gate), 1);
        tick(1); chk("t3_gate_b", int'(bus.gate), 0);
        chk("t3_pulse_b", int'(bus.step_pulse), 0);
        tick(1); chk("t3_gate_c", int'(bus.gate), 1);
        chk("t3_idx_c", int'(bus.beat_idx), 1);
        pulse_stop();

        // pause at counter 2 of step 5, period 8
        bus.beats = {NB{4'h9}}; bus.step_period = 8; bus.gate_len = 4;
        pulse_start();
        tick(42);
        chk("t4_idx5", int'(bus.beat_idx), 5);
        bus.pause = 1'b1; tick(1); bus.pause = 1'b0;
        chk("t4_paused_run", int'(bus.running), 0);
        chk("t4_paused_gate", int'(bus.gate), 0);
        tick(19);
        chk("t4_hold_idx", int'(bus.beat_idx), 5);
        chk("t4_hold_gate", int'(bus.gate), 0);
        pulse_start();
        chk("t4_resume_run", int'(bus.running), 1);
        chk("t4_resume_gate", int'(bus.gate), 1);
        chk("t4_resume_pulse", int'(bus.step_pulse), 0);
        wait_pulse(n);
        chk("t4_resume_dist", n, 6);
        chk("t4_idx6", int'(bus.beat_idx), 6);

        // stop beats start in the same cycle
        bus.stop = 1'b1; bus.start = 1'b1; tick(1);
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("t5_run", int'(bus.running), 0);
        chk("t5_gate", int'(bus.gate), 0);
        chk("t5_pulse", int'(bus.step_pulse), 0);
        tick(3);
        chk("t5_still", int'(bus.running), 0);

`ifdef BEAT_PLAYER_LOOP_LEN_EN
        bus.loop_len = 4'd3; bus.step_period = 2; bus.gate_len = 1;
        pulse_start();
        chk("t6_idx0", int'(bus.beat_idx), 0);
        for (int i = 1; i <= 4; i++) begin
            wait_pulse(n);
            chk("t6_seq", int'(bus.beat_idx), i % 4);
        end
        n = 0;
        while (bus.beat_idx != 4'd3 && n < 20) begin tick(1); n++; end
        bus.loop_len = 4'd1;
        wait_pulse(n);
        chk("t6_lowered", int'(bus.beat_idx), 0);
        pulse_stop();
`endif

        // asynchronous reset mid-step
        bus.step_period = 4; bus.gate_len = 2;
        pulse_start();
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_run", int'(bus.running), 0);
        chk("arst_gate", int'(bus.gate), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
